// File: rtl/wb_master_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter_pkg
// Shared Wishbone B4 types and constants for the master-side arbiter:
//   - wb_master_t / wb_slave_t : request and response bundles
//   - WB_CTI_* / WB_BTE_*      : cycle-type and burst-type encodings
//   - wb_arb_state_e           : arbiter FSM states
//   - WB_ARB_NUM_MASTERS       : default number of requesters
//   - wb_arb_wrap_inc()        : modulo-n increment for the round-robin pointer
// -----------------------------------------------------------------------------
package wb_master_arbiter_pkg;

    localparam int WB_ARB_NUM_MASTERS = 2;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_CONST   = 3'b001;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } wb_master_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
        logic [31:0] dat;
    } wb_slave_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        BUSY         = 2'd1,
        TIMEOUT      = 2'd2,
        WAIT_RELEASE = 2'd3
    } wb_arb_state_e;

    // Request side driven toward the interconnect when nobody owns the bus.
    localparam wb_master_t WB_M_IDLE = '{
        cyc: 1'b0, stb: 1'b0, we: 1'b0, adr: 32'h0, dat: 32'h0,
        sel: 4'h0, cti: WB_CTI_CLASSIC, bte: WB_BTE_LINEAR
    };

    // Response seen by any master that does not own the bus.
    localparam wb_slave_t WB_S_IDLE = '{
        ack: 1'b0, err: 1'b0, rty: 1'b0, stall: 1'b1, dat: 32'h0
    };

    // Next round-robin position after idx, wrapping at n.
    function automatic int wb_arb_wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// wb_rr_picker
// Combinational round-robin selector: returns the first requester at or
// after ptr_i (modulo N), both one-hot and encoded.
// Ports:
//   req_i   [N]      request vector
//   ptr_i   [IDX_W]  round-robin start position
//   gnt_o   [N]      one-hot winner (zero when no request)
//   idx_o   [IDX_W]  encoded winner (zero when no request)
//   valid_o          at least one request present
// -----------------------------------------------------------------------------
module wb_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int               c_s;
    logic [IDX_W-1:0] cidx_s;

    // Scan N positions starting at ptr_i; the first hit wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        c_s     = 0;
        cidx_s  = '0;
        for (int k = 0; k < N; k++) begin
            c_s    = (int'(ptr_i) + k) % N;
            cidx_s = IDX_W'(c_s);
            if (!valid_o && req_i[cidx_s]) begin
                valid_o       = 1'b1;
                gnt_o[cidx_s] = 1'b1;
                idx_o         = cidx_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_master_arbiter
// Shares one Wishbone B4 pipelined master port among NUM_MASTERS requesters.
// Round-robin, registered grant, held for the whole cyc so bursts and
// outstanding pipelined beats are never split. At least one IDLE cycle
// separates consecutive grants.
// Optional bus watchdog: compile with WB_ARB_TIMEOUT_EN to abort a cycle
// that sees no ack for TIMEOUT_CYCLES busy cycles.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   wb_m_i[N]      requests from the masters
//   wb_s_o[N]      responses to the masters
//   wb_m_o         muxed request to the interconnect
//   wb_s_i         response from the interconnect
//   grant_o[N]     registered one-hot grant, zero when idle
//   busy_o         registered, high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = WB_ARB_NUM_MASTERS,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  wb_master_t [NUM_MASTERS-1:0] wb_m_i,
    output wb_slave_t  [NUM_MASTERS-1:0] wb_s_o,
    output wb_master_t                   wb_m_o,
    input  wb_slave_t                    wb_s_i,
    output logic       [NUM_MASTERS-1:0] grant_o,
    output logic                         busy_o
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    wb_arb_state_e          state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       gidx_q, gidx_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   busy_q, busy_d;

    logic [NUM_MASTERS-1:0] req_s;
    logic [NUM_MASTERS-1:0] pick_gnt_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic                   pick_valid_s;
    logic                   g_cyc_s;
    logic [IDX_W-1:0]       next_ptr_s;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_req
        assign req_s[gi] = wb_m_i[gi].cyc;
    end

    wb_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (req_s),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    assign g_cyc_s    = wb_m_i[gidx_q].cyc;
    assign next_ptr_s = IDX_W'(wb_arb_wrap_inc(int'(gidx_q), NUM_MASTERS));

    // Next-state, grant and pointer computation.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
`ifdef WB_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = BUSY;
                    grant_d = pick_gnt_s;
                    gidx_d  = pick_idx_s;
`ifdef WB_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Owner dropping cyc is the only release point.
                if (!g_cyc_s) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_s;
                end else begin
`ifdef WB_ARB_TIMEOUT_EN
                    if (wb_s_i.ack) begin
                        tmo_cnt_d = '0;
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = TIMEOUT;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                    end
`else
                    state_d = BUSY;
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            TIMEOUT: begin
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!g_cyc_s) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d = WAIT_RELEASE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    // Bus muxing: the owner is wired straight through while BUSY so the
    // pipelined protocol keeps its zero-latency stall/ack behaviour.
    always_comb begin
        wb_m_o = WB_M_IDLE;
        wb_s_o = {NUM_MASTERS{WB_S_IDLE}};
        case (state_q)
            BUSY: begin
                wb_m_o         = wb_m_i[gidx_q];
                wb_s_o[gidx_q] = wb_s_i;
                // A releasing master must not leave a dangling strobe.
                if (!g_cyc_s) begin
                    wb_m_o.stb = 1'b0;
                end else begin
                    wb_m_o.stb = wb_m_i[gidx_q].stb;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            TIMEOUT: begin
                wb_s_o[gidx_q].err = 1'b1;
            end
`endif
            default: begin
                wb_m_o = WB_M_IDLE;
            end
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;
    import wb_master_arbiter_pkg::*;

    localparam int NM = 2;

    logic                clk = 1'b0;
    logic                rst;
    wb_master_t [NM-1:0] m_i;
    wb_slave_t  [NM-1:0] s_o;
    wb_master_t          m_o;
    wb_slave_t           s_i;
    logic       [NM-1:0] grant;
    logic                busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          idx;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb_m_i  (m_i),
        .wb_s_o  (s_o),
        .wb_m_o  (m_o),
        .wb_s_i  (s_i),
        .grant_o (grant),
        .busy_o  (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic wb_master_t mreq(input logic [31:0] adr, input logic [2:0] cti);
        wb_master_t r;
        r     = '0;
        r.cyc = 1'b1;
        r.stb = 1'b1;
        r.adr = adr;
        r.sel = 4'hF;
        r.cti = cti;
        return r;
    endfunction

    // Drive a slave ack and record who must receive it.
    task automatic slave_ack(input int idx, input logic [31:0] dat);
        exp_t e;
        s_i.ack = 1'b1;
        s_i.dat = dat;
        e.idx   = idx;
        e.dat   = dat;
        sb.push_back(e);
    endtask

    // Scoreboard check of one master's response port.
    task automatic mon(input int idx, input wb_slave_t s);
        exp_t e;
        if (s.ack === 1'b1) begin
            chk("ack_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_master", 64'(idx), 64'(e.idx));
                chk("ack_data", 64'(s.dat), 64'(e.dat));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, s_o[0]);
        mon(1, s_o[1]);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        m_i = '0;
        s_i = '0;
        repeat (3) step();

        // Reset state
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_cyc", 64'(m_o.cyc), 64'd0);
        chk("rst_m_stb", 64'(m_o.stb), 64'd0);
        chk("rst_m_we", 64'(m_o.we), 64'd0);
        chk("rst_m_cti", 64'(m_o.cti), 64'(WB_CTI_CLASSIC));
        chk("rst_m_bte", 64'(m_o.bte), 64'(WB_BTE_LINEAR));
        chk("rst_s0_stall", 64'(s_o[0].stall), 64'd1);
        chk("rst_s1_stall", 64'(s_o[1].stall), 64'd1);
        chk("rst_s0_ack", 64'({s_o[0].ack, s_o[0].err, s_o[0].rty}), 64'd0);
        rst = 1'b0;

        // Single master read at 0x2000_0010
        step();
        m_i[0] = mreq(32'h2000_0010, WB_CTI_CLASSIC);
        #1;
        chk("t1_no_grant_yet", 64'(grant), 64'd0);
        chk("t1_no_cyc_yet", 64'(m_o.cyc), 64'd0);
        step();
        chk("t1_grant", 64'(grant), 64'b01);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_m_cyc", 64'(m_o.cyc), 64'd1);
        chk("t1_m_adr", 64'(m_o.adr), 64'h2000_0010);
        chk("t1_s0_stall", 64'(s_o[0].stall), 64'd0);
        chk("t1_s1_stall", 64'(s_o[1].stall), 64'd1);
        step();
        m_i[0].stb = 1'b0;
        step();
        slave_ack(0, 32'hCAFE_0010);
        #1;
        chk("t1_s1_noack", 64'(s_o[1].ack), 64'd0);
        step();
        s_i.ack = 1'b0;
        m_i[0]  = '0;
        #1;
        chk("t1_release_cyc", 64'(m_o.cyc), 64'd0);
        step();
        chk("t1_busy_drop", 64'(busy), 64'd0);
        chk("t1_grant_drop", 64'(grant), 64'd0);

        // Contention from reset
        rst = 1'b1;
        step();
        rst    = 1'b0;
        m_i[0] = mreq(32'h1000_0000, WB_CTI_CLASSIC);
        m_i[1] = mreq(32'h3000_0000, WB_CTI_CLASSIC);
        step();
        chk("t2_grant_m0", 64'(grant), 64'b01);
        chk("t2_m_adr", 64'(m_o.adr), 64'h1000_0000);
        chk("t2_s1_stall", 64'(s_o[1].stall), 64'd1);
        step();
        slave_ack(0, 32'hAAAA_0001);
        m_i[0] = '0;
        #1;
        chk("t2_drop_cyc", 64'(m_o.cyc), 64'd0);
        chk("t2_drop_stb", 64'(m_o.stb), 64'd0);
        chk("t2_ack_on_drop", 64'(s_o[0].ack), 64'd1);
        step();
        s_i.ack = 1'b0;
        chk("t2_idle_gap", 64'(grant), 64'd0);
        chk("t2_idle_busy", 64'(busy), 64'd0);
        chk("t2_idle_s1_stall", 64'(s_o[1].stall), 64'd1);
        step();
        chk("t2_grant_m1", 64'(grant), 64'b10);
        chk("t2_m1_adr", 64'(m_o.adr), 64'h3000_0000);
        step();
        m_i[1] = '0;
        step();
        m_i[0] = mreq(32'h1000_0004, WB_CTI_CLASSIC);
        m_i[1] = mreq(32'h3000_0004, WB_CTI_CLASSIC);
        step();
        chk("t2_second_m0", 64'(grant), 64'b01);
        step();
        m_i[0] = '0;
        m_i[1] = '0;
        step();
        chk("t2_end_idle", 64'(grant), 64'd0);

        // Burst lock: M0 4-beat INCR/EOB, M1 requests on beat 1
        m_i[0] = mreq(32'h8000_0040, WB_CTI_INCR);
        step();
        chk("t3_grant_m0", 64'(grant), 64'b01);
        chk("t3_cti_incr", 64'(m_o.cti), 64'(WB_CTI_INCR));
        step();
        m_i[0].adr = 32'h8000_0044;
        slave_ack(0, 32'hB000_0000);
        m_i[1] = mreq(32'h3000_0008, WB_CTI_CLASSIC);
        #1;
        chk("t3_b1_s1_stall", 64'(s_o[1].stall), 64'd1);
        chk("t3_b1_grant", 64'(grant), 64'b01);
        step();
        m_i[0].adr = 32'h8000_0048;
        slave_ack(0, 32'hB000_0001);
        #1;
        chk("t3_b2_grant", 64'(grant), 64'b01);
        chk("t3_b2_adr", 64'(m_o.adr), 64'h8000_0048);
        step();
        m_i[0].adr = 32'h8000_004C;
        m_i[0].cti = WB_CTI_EOB;
        slave_ack(0, 32'hB000_0002);
        #1;
        chk("t3_cti_eob", 64'(m_o.cti), 64'(WB_CTI_EOB));
        step();
        m_i[0].stb = 1'b0;
        slave_ack(0, 32'hB000_0003);
        #1;
        chk("t3_b4_grant", 64'(grant), 64'b01);
        step();
        s_i.ack = 1'b0;
        m_i[0]  = '0;
        #1;
        chk("t3_rel_s1_stall", 64'(s_o[1].stall), 64'd1);
        step();
        chk("t3_idle", 64'(grant), 64'd0);
        step();
        chk("t3_grant_m1", 64'(grant), 64'b10);
        chk("t3_m1_stall", 64'(s_o[1].stall), 64'd0);
        m_i[1] = '0;
        step();
        step();

        // Stray ack while idle
        s_i.ack = 1'b1;
        s_i.dat = 32'hDEAD_BEEF;
        #1;
        chk("t4_s0_noack", 64'(s_o[0].ack), 64'd0);
        chk("t4_s1_noack", 64'(s_o[1].ack), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        step();
        s_i.ack = 1'b0;
        chk("t4_busy_after", 64'(busy), 64'd0);
        chk("t4_grant_after", 64'(grant), 64'd0);

        // Reset mid-burst
        m_i[0] = mreq(32'h8000_0080, WB_CTI_INCR);
        step();
        chk("t5_grant_m0", 64'(grant), 64'b01);
        step();
        m_i[0].adr = 32'h8000_0084;
        slave_ack(0, 32'hC000_0000);
        step();
        s_i.ack    = 1'b0;
        m_i[0].adr = 32'h8000_0088;
        rst        = 1'b1;
        #1;
        chk("t5_cyc_before_edge", 64'(m_o.cyc), 64'd1);
        step();
        chk("t5_rst_cyc", 64'(m_o.cyc), 64'd0);
        chk("t5_rst_grant", 64'(grant), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_s0_stall", 64'(s_o[0].stall), 64'd1);
        chk("t5_rst_s1_stall", 64'(s_o[1].stall), 64'd1);
        rst    = 1'b0;
        m_i[0] = '0;
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never acks
        m_i[0] = mreq(32'h4000_0000, WB_CTI_CLASSIC);
        step();
        chk("t6_grant_m0", 64'(grant), 64'b01);
        m_i[0].stb = 1'b0;
        m_i[1]     = mreq(32'h3000_000C, WB_CTI_CLASSIC);
        for (int k = 2; k <= 16; k++) begin
            step();
        end
        #1;
        chk("t6_b16_err", 64'(s_o[0].err), 64'd0);
        chk("t6_b16_cyc", 64'(m_o.cyc), 64'd1);
        step();
        chk("t6_tmo_err", 64'(s_o[0].err), 64'd1);
        chk("t6_tmo_cyc", 64'(m_o.cyc), 64'd0);
        chk("t6_tmo_stb", 64'(m_o.stb), 64'd0);
        chk("t6_tmo_s1_err", 64'(s_o[1].err), 64'd0);
        step();
        s_i.ack = 1'b1;
        s_i.dat = 32'h1A7E_0000;
        #1;
        chk("t6_late_ack_drop", 64'(s_o[0].ack), 64'd0);
        chk("t6_err_one_cycle", 64'(s_o[0].err), 64'd0);
        chk("t6_wait_stall", 64'(s_o[0].stall), 64'd1);
        chk("t6_wait_cyc", 64'(m_o.cyc), 64'd0);
        step();
        s_i.ack = 1'b0;
        m_i[0]  = '0;
        #1;
        chk("t6_wait_grant", 64'(grant), 64'b01);
        step();
        chk("t6_idle", 64'(grant), 64'd0);
        step();
        chk("t6_grant_m1", 64'(grant), 64'b10);
        m_i[1] = '0;
        step();
        step();
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
